// File: rtl/calc_pkg.sv
// Shared types for the four-function BCD calculator.
// Combinational definitions only; no latency.
// No flow control; types and button codes only.
package calc_pkg;

  localparam int NumDigits = 8;

  typedef logic [3:0] bcd_t;

  // value = d7.d6..d0 x 10^exponent, significand[7] is the leading digit
  typedef struct packed {
    logic                     sign;
    logic [2:0]               exponent;
    bcd_t [NumDigits-1:0]     significand;
  } num_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_t;

  // Plain vector so that undefined codes can reach the controller and be ignored
  typedef logic [4:0] active_button_t;

  localparam active_button_t B_NONE   = 5'd0;
  localparam active_button_t B_NUM_0  = 5'd1;
  localparam active_button_t B_NUM_9  = 5'd10;
  localparam active_button_t B_OP_ADD = 5'd11;
  localparam active_button_t B_OP_SUB = 5'd12;
  localparam active_button_t B_OP_MUL = 5'd13;
  localparam active_button_t B_OP_DIV = 5'd14;
  localparam active_button_t B_OP_EQ  = 5'd15;
  localparam active_button_t B_CLEAR  = 5'd16;

endpackage

// File: rtl/calc_controller.sv
// Sequencing FSM of the BCD calculator: digit entry, operators, equals/repeat, ALU handshake.
// Digit/operator/clear events complete in one cycle; ALU operations take REQ + WAIT cycles.
// Button events are dropped while an ALU transaction is outstanding; ALU side is valid/ready.
module calc_controller
  import calc_pkg::*;
(
  input  logic           clk_i,
  input  logic           rst_i,
  input  active_button_t active_button_i,
  input  logic           new_input_i,
  output logic           override_shift_amount_o,
  output logic [2:0]     new_shift_amount_o,
  output logic           display_we_o,
  output num_t           display_wdata_o,
  input  num_t           display_rdata_i,
  output logic           upper_we_o,
  output num_t           upper_wdata_o,
  input  num_t           upper_rdata_i,
  output num_t           alu_left_o,
  output num_t           alu_right_o,
  output op_t            alu_op_o,
  input  logic           alu_in_ready_i,
  output logic           alu_in_valid_o,
  input  num_t           alu_result_i,
  output logic           alu_out_ready_o,
  input  logic           alu_out_valid_i
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  localparam logic [1:0] MODE_REPEAT  = 2'd0;
  localparam logic [1:0] MODE_FRESH   = 2'd1;
  localparam logic [1:0] MODE_PENDING = 2'd2;

  logic [1:0] state_q, state_d;
  logic [1:0] mode_q, mode_d;
  op_t        op_q, op_d;
  op_t        next_op_q, next_op_d;
  logic       new_entry_q, new_entry_d;
  logic [3:0] digits_q, digits_d;
  logic       chain_q, chain_d;
  num_t       alu_left_q, alu_left_d;
  num_t       alu_right_q, alu_right_d;
  op_t        alu_op_q, alu_op_d;

  logic       display_we, upper_we;
  num_t       display_wdata, upper_wdata;

  logic       btn_digit, btn_op;
  bcd_t       btn_val;
  op_t        btn_op_val;
  logic [2:0] dig_idx;

  // Button decode: digit value and operator code from the raw button code
  always_comb begin
    btn_digit  = (active_button_i >= B_NUM_0) && (active_button_i <= B_NUM_9);
    btn_op     = (active_button_i >= B_OP_ADD) && (active_button_i <= B_OP_DIV);
    btn_val    = 4'(active_button_i - B_NUM_0);
    btn_op_val = op_t'(2'(active_button_i - B_OP_ADD));
    dig_idx    = 3'd7 - digits_q[2:0];
  end

  // Next-state, register writes and ALU handshake
  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    op_d          = op_q;
    next_op_d     = next_op_q;
    new_entry_d   = new_entry_q;
    digits_d      = digits_q;
    chain_d       = chain_q;
    alu_left_d    = alu_left_q;
    alu_right_d   = alu_right_q;
    alu_op_d      = alu_op_q;
    display_we    = 1'b0;
    display_wdata = '0;
    upper_we      = 1'b0;
    upper_wdata   = '0;
    alu_in_valid_o  = 1'b0;
    alu_out_ready_o = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (new_input_i) begin
          if (btn_digit) begin
            display_we  = 1'b1;
            new_entry_d = 1'b0;
            if (new_entry_q) begin
              // First digit of a new number replaces the display
              display_wdata.significand[NumDigits-1] = btn_val;
              digits_d = (btn_val != 4'd0) ? 4'd1 : 4'd0;
              if (mode_q == MODE_FRESH) begin
                // Operand typed after an operator: park the old value as the other operand
                upper_we    = 1'b1;
                upper_wdata = display_rdata_i;
                mode_d      = MODE_PENDING;
              end
            end else begin
              display_wdata = display_rdata_i;
              // Leading zeros leave the count at zero; digits beyond eight are dropped
              if (digits_q < 4'd8 && (digits_q != 4'd0 || btn_val != 4'd0)) begin
                display_wdata.significand[dig_idx] = btn_val;
                display_wdata.exponent             = digits_q[2:0];
                digits_d                           = digits_q + 4'd1;
              end
            end
          end else if (btn_op) begin
            if (mode_q == MODE_PENDING) begin
              // Chained operator: evaluate the pending operation first
              chain_d     = 1'b1;
              next_op_d   = btn_op_val;
              alu_left_d  = upper_rdata_i;
              alu_right_d = display_rdata_i;
              alu_op_d    = op_q;
              state_d     = ST_REQ;
            end else begin
              op_d        = btn_op_val;
              mode_d      = MODE_FRESH;
              new_entry_d = 1'b1;
              digits_d    = 4'd0;
            end
          end else if (active_button_i == B_OP_EQ) begin
            chain_d  = 1'b0;
            alu_op_d = op_q;
            if (mode_q == MODE_PENDING) begin
              alu_left_d  = upper_rdata_i;
              alu_right_d = display_rdata_i;
            end else begin
              alu_left_d  = display_rdata_i;
              alu_right_d = upper_rdata_i;
            end
            state_d = ST_REQ;
          end else if (active_button_i == B_CLEAR) begin
            display_we  = 1'b1;
            upper_we    = 1'b1;
            op_d        = OP_ADD;
            mode_d      = MODE_REPEAT;
            new_entry_d = 1'b1;
            digits_d    = 4'd0;
          end
        end
      end

      ST_REQ: begin
        alu_in_valid_o = 1'b1;
        if (alu_in_ready_i) state_d = ST_WAIT;
      end

      ST_WAIT: begin
        alu_out_ready_o = 1'b1;
        if (alu_out_valid_i) begin
          display_we    = 1'b1;
          display_wdata = alu_result_i;
          new_entry_d   = 1'b1;
          digits_d      = 4'd0;
          state_d       = ST_IDLE;
          if (chain_q) begin
            upper_we    = 1'b1;
            upper_wdata = alu_result_i;
            op_d        = next_op_q;
            mode_d      = MODE_FRESH;
          end else begin
            // Repeated equals keeps the other operand so it can be reapplied
            if (mode_q != MODE_REPEAT) begin
              upper_we    = 1'b1;
              upper_wdata = display_rdata_i;
            end
            mode_d = MODE_REPEAT;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (rst_i) begin
      alu_in_valid_o  = 1'b0;
      alu_out_ready_o = 1'b0;
    end
  end

  // Outputs are forced quiet while reset is held
  always_comb begin
    display_we_o            = display_we & ~rst_i;
    upper_we_o              = upper_we & ~rst_i;
    display_wdata_o         = rst_i ? '0 : display_wdata;
    upper_wdata_o           = rst_i ? '0 : upper_wdata;
    override_shift_amount_o = ~rst_i & ~new_entry_q & (digits_q != 4'd0);
    new_shift_amount_o      = rst_i ? 3'd0 : (digits_q[2:0] - 3'd1);
    alu_left_o              = alu_left_q;
    alu_right_o             = alu_right_q;
    alu_op_o                = alu_op_q;
  end

  // State registers with synchronous reset; reset abandons any ALU transaction
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_REPEAT;
      op_q        <= OP_ADD;
      next_op_q   <= OP_ADD;
      new_entry_q <= 1'b1;
      digits_q    <= 4'd0;
      chain_q     <= 1'b0;
      alu_left_q  <= '0;
      alu_right_q <= '0;
      alu_op_q    <= OP_ADD;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      op_q        <= op_d;
      next_op_q   <= next_op_d;
      new_entry_q <= new_entry_d;
      digits_q    <= digits_d;
      chain_q     <= chain_d;
      alu_left_q  <= alu_left_d;
      alu_right_q <= alu_right_d;
      alu_op_q    <= alu_op_d;
    end
  end

endmodule

// File: tb/tb_calc_controller.sv
// Bench for calc_controller: external display/upper registers, integer ALU, and a calculator model.
// Each key press is checked once the controller is idle again.
// The ALU responder applies configurable ready/valid delays.
module tb_calc_controller;
  import calc_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  active_button_t active_button;
  logic           new_input;
  logic           override_shift_amount;
  logic [2:0]     new_shift_amount;
  logic           display_we, upper_we;
  num_t           display_wdata, upper_wdata;
  num_t           display_q, upper_q;
  num_t           alu_left, alu_right, alu_result;
  op_t            alu_op;
  logic           alu_in_ready, alu_in_valid, alu_out_ready, alu_out_valid;

  calc_controller dut (
    .clk_i                   (clk),
    .rst_i                   (rst),
    .active_button_i         (active_button),
    .new_input_i             (new_input),
    .override_shift_amount_o (override_shift_amount),
    .new_shift_amount_o      (new_shift_amount),
    .display_we_o            (display_we),
    .display_wdata_o         (display_wdata),
    .display_rdata_i         (display_q),
    .upper_we_o              (upper_we),
    .upper_wdata_o           (upper_wdata),
    .upper_rdata_i           (upper_q),
    .alu_left_o              (alu_left),
    .alu_right_o             (alu_right),
    .alu_op_o                (alu_op),
    .alu_in_ready_i          (alu_in_ready),
    .alu_in_valid_o          (alu_in_valid),
    .alu_result_i            (alu_result),
    .alu_out_ready_o         (alu_out_ready),
    .alu_out_valid_i         (alu_out_valid)
  );

  // External display/upper registers
  always @(posedge clk) begin
    if (rst) begin
      display_q <= '0;
      upper_q   <= '0;
    end else begin
      if (display_we) display_q <= display_wdata;
      if (upper_we)   upper_q   <= upper_wdata;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  function automatic int to_int(input num_t n);
    int v = 0;
    for (int i = 7; i >= 0; i--)
      if ((7 - i) <= int'(n.exponent)) v = v * 10 + int'(n.significand[i]);
    return n.sign ? -v : v;
  endfunction

  function automatic num_t to_num(input int v);
    num_t n = '0;
    int   q[$];
    int   t;
    if (v == 0) return n;
    if (v < 0) begin n.sign = 1'b1; t = -v; end else t = v;
    while (t > 0) begin q.push_front(t % 10); t = t / 10; end
    for (int j = 0; j < q.size() && j < 8; j++) n.significand[7 - j] = 4'(q[j]);
    n.exponent = 3'(q.size() - 1);
    return n;
  endfunction

  function automatic int ndig(input int v);
    int c = 0;
    int t = (v < 0) ? -v : v;
    while (t > 0) begin c++; t = t / 10; end
    return c;
  endfunction

  function automatic int alu_fn(input int l, input int r, input op_t o);
    case (o)
      OP_ADD:  return l + r;
      OP_SUB:  return l - r;
      OP_MUL:  return l * r;
      default: return (r == 0) ? 0 : l / r;
    endcase
  endfunction

  // ALU responder
  int in_dly = 0, out_dly = 0;
  num_t l0, r0;
  op_t  o0;
  initial begin
    alu_in_ready  = 1'b0;
    alu_out_valid = 1'b0;
    alu_result    = '0;
    forever begin
      @(negedge clk);
      if (alu_in_valid && !rst) begin
        l0 = alu_left; r0 = alu_right; o0 = alu_op;
        repeat (in_dly) @(negedge clk);
        chk("alu_operands_held", longint'(alu_in_valid && alu_left == l0 && alu_right == r0 && alu_op == o0), 1);
        alu_in_ready = 1'b1;
        @(negedge clk);
        alu_in_ready = 1'b0;
        repeat (out_dly) @(negedge clk);
        alu_result    = to_num(alu_fn(to_int(l0), to_int(r0), o0));
        alu_out_valid = 1'b1;
        @(negedge clk);
        alu_out_valid = 1'b0;
        alu_result    = '0;
      end
    end
  end

  // Calculator model: values as integers, modes as the user-visible rules
  localparam int M_REPEAT = 0, M_FRESH = 1, M_PENDING = 2;
  int  m_d, m_u, m_mode;
  op_t m_op;
  bit  m_new;

  task automatic model_reset();
    m_d = 0; m_u = 0; m_mode = M_REPEAT; m_op = OP_ADD; m_new = 1'b1;
  endtask

  task automatic model_apply(input byte c);
    int r;
    op_t o;
    if (c >= 8'd48 && c <= 8'd57) begin
      if (m_new) begin
        if (m_mode == M_FRESH) begin m_u = m_d; m_mode = M_PENDING; end
        m_d = int'(c) - 48;
        m_new = 1'b0;
      end else if (ndig(m_d) < 8) begin
        m_d = m_d * 10 + (int'(c) - 48);
      end
    end else if (c == "+" || c == "-" || c == "*" || c == "/") begin
      o = (c == "+") ? OP_ADD : (c == "-") ? OP_SUB : (c == "*") ? OP_MUL : OP_DIV;
      if (m_mode == M_PENDING) begin
        r = alu_fn(m_u, m_d, m_op);
        m_d = r; m_u = r;
      end
      m_op = o; m_mode = M_FRESH; m_new = 1'b1;
    end else if (c == "=") begin
      if (m_mode == M_PENDING) begin r = alu_fn(m_u, m_d, m_op); m_u = m_d; m_d = r; end
      else if (m_mode == M_FRESH) begin r = alu_fn(m_d, m_u, m_op); m_u = m_d; m_d = r; end
      else m_d = alu_fn(m_d, m_u, m_op);
      m_mode = M_REPEAT; m_new = 1'b1;
    end else if (c == "C") begin
      model_reset();
    end
  endtask

  function automatic active_button_t to_btn(input byte c);
    case (c)
      "+": return B_OP_ADD;
      "-": return B_OP_SUB;
      "*": return B_OP_MUL;
      "/": return B_OP_DIV;
      "=": return B_OP_EQ;
      "C": return B_CLEAR;
      "N": return B_NONE;
      "X": return 5'd31;
      default: return active_button_t'(B_NUM_0 + 5'(c - 8'd48));
    endcase
  endfunction

  task automatic do_reset();
    rst = 1'b1; new_input = 1'b0; active_button = B_NONE;
    in_dly = 0; out_dly = 0;
    repeat (2) @(negedge clk);
    chk("rst_display_we", display_we, 0);
    chk("rst_upper_we", upper_we, 0);
    chk("rst_in_valid", alu_in_valid, 0);
    chk("rst_out_ready", alu_out_ready, 0);
    chk("rst_override", override_shift_amount, 0);
    chk("rst_wdata", longint'(display_wdata) | longint'(upper_wdata), 0);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk("rst_display", longint'(display_q), 0);
  endtask

  // Press one key, optionally spraying extra key events while the ALU is busy
  task automatic press(input active_button_t b, input bit noise);
    bit done = 1'b0;
    active_button = b; new_input = 1'b1;
    @(negedge clk);
    new_input = 1'b0; active_button = B_NONE;
    for (int i = 0; i < 60; i++) begin
      new_input = 1'b0;
      if (!alu_in_valid && !alu_out_ready) begin done = 1'b1; break; end
      if (noise) begin
        active_button = (i % 2 == 1) ? B_CLEAR : B_NUM_9;
        new_input = 1'b1;
      end
      @(negedge clk);
    end
    new_input = 1'b0; active_button = B_NONE;
    chk("press_completes", done, 1);
  endtask

  int exp_d[$];
  int exp_u[$];

  task automatic run_seq(input string s, input bit noise);
    for (int i = 0; i < s.len(); i++) begin
      model_apply(s[i]);
      press(to_btn(s[i]), noise);
      chk($sformatf("display[%s@%0d]", s, i), longint'(display_q), longint'(to_num(m_d)));
      chk($sformatf("upper[%s@%0d]", s, i), longint'(upper_q), longint'(to_num(m_u)));
      chk($sformatf("override[%s@%0d]", s, i), override_shift_amount, longint'(!m_new && m_d != 0));
      if (!m_new && m_d != 0)
        chk($sformatf("shift[%s@%0d]", s, i), new_shift_amount, ndig(m_d) - 1);
      if (i < exp_d.size()) chk($sformatf("lit_display[%s@%0d]", s, i), to_int(display_q), exp_d[i]);
      if (i < exp_u.size()) chk($sformatf("lit_upper[%s@%0d]", s, i), to_int(upper_q), exp_u[i]);
    end
    exp_d = {};
    exp_u = {};
  endtask

  initial begin
    do_reset();
    exp_d = '{1, 1, 1, 2, 3, 4, 5}; exp_u = '{0, 0, 1, 1, 1, 1, 1};
    run_seq("1+=====", 1'b0);

    do_reset();
    exp_d = '{3, 3, 1, 1, 1, 2}; exp_u = '{0, 0, 0, 0, 1, 1};
    run_seq("3=1+==", 1'b0);

    do_reset();
    exp_d = '{0, 3, 3, 1, 1, 4, 5, 6, 7, 8}; exp_u = '{0, 0, 3, 3, 3, 1, 1, 1, 1, 1};
    run_seq("+3=1+=====", 1'b0);

    do_reset();
    exp_d = '{1, 1, 1, 2, 2, 3, 3, 5, 5, 8, 8};
    run_seq("1+1=+=+=+=+", 1'b0);

    do_reset();
    exp_d = '{1, 1, 1, 1, 1, 1, 1}; exp_u = '{0, 0, 0, 0, 0, 0, 0};
    run_seq("1======", 1'b0);

    do_reset();
    exp_d = '{2, 2, 3, 5, 4, 20}; exp_u = '{0, 0, 2, 5, 5, 4};
    run_seq("2+3*4=", 1'b0);

    // Subtraction to a negative, repeated multiply, division, clear, ignored codes
    exp_d = '{0, 2, 2, 5, -3, 3, 3, 4, 12, 48};
    run_seq("C2-5=3*4==", 1'b0);
    run_seq("CNX9/2=X", 1'b0);

    // Entry width: leading zeros, nine digits
    exp_d = '{0, 0, 0, 1, 12};
    run_seq("C0012", 1'b0);
    exp_d = '{0, 1, 12, 123, 1234, 12345, 123456, 1234567, 12345678, 12345678};
    run_seq("C123456789", 1'b0);

    // Slow ALU with key events during the transaction
    do_reset();
    in_dly = 3; out_dly = 4;
    exp_d = '{5, 5, 4, 9}; exp_u = '{0, 0, 5, 4};
    run_seq("5+4=", 1'b1);
    in_dly = 0; out_dly = 0;
    exp_d = '{1, 12, 123};
    run_seq("123", 1'b0);
    chk("final_override", override_shift_amount, 1);
    chk("final_shift", new_shift_amount, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule

// File: doc/calc_controller.md
Name: calc_controller

Overview:
- Sequencing FSM of the four-function BCD calculator, driven by debounced button events.
- Owns digit entry, operator latching, equals/repeat semantics and the ALU handshake.
- Writes two external calc_pkg::num_t registers: display (shown on screen) and upper (other operand).
- Drives screen_driver shift override during digit entry.

Parameters:
- None. All types (num_t, op_t, active_button_t, bcd_t, NumDigits=8) come from calc_pkg.

Ports:
- clk_i  in  1  clock; single clock domain.
- rst_i  in  1  reset, synchronous, active-high.
- active_button_i  in  active_button_t  button code; valid when new_input_i=1.
- new_input_i  in  1  one-cycle event strobe.
- override_shift_amount_o  out  1  screen_driver uses new_shift_amount_o instead of its own normalisation.
- new_shift_amount_o  out  3  digits entered minus 1.
- display_we_o  out  1  display register write enable.
- display_wdata_o  out  num_t  display write data.
- display_rdata_i  in  num_t  display current value (D).
- upper_we_o  out  1  upper register write enable.
- upper_wdata_o  out  num_t  upper write data.
- upper_rdata_i  in  num_t  upper current value (U).
- alu_left_o  out  num_t  ALU left operand.
- alu_right_o  out  num_t  ALU right operand.
- alu_op_o  out  op_t  ALU operation.
- alu_in_ready_i  in  1  ALU accepts operands.
- alu_in_valid_o  out  1  operand request.
- alu_result_i  in  num_t  ALU result.
- alu_out_ready_o  out  1  controller accepts result.
- alu_out_valid_i  in  1  result available.

Behaviour:
- num_t: sign, 3-bit exponent, significand[7:0] of BCD. significand[7] is the leading digit. Value = d7.d6..d0 x 10^exponent. Zero = all fields 0.
- state_q encoding: IDLE=0, REQ, WAIT.
  - IDLE: new_input_i accepted only here; ignored in any other state.
  - REQ: alu_in_valid_o=1 with operands held stable; advance to WAIT on alu_in_ready_i.
  - WAIT: alu_out_ready_o=1; on alu_out_valid_i, write the result in that cycle and return to IDLE.
- Internal state:
  - op_q: reset OP_ADD.
  - mode_q in {REPEAT, FRESH, PENDING}: reset REPEAT.
  - new_entry_q: reset 1.
  - digits_q: 0..8, reset 0.
- Reset: state IDLE; all write enables, alu_in_valid_o, alu_out_ready_o and override_shift_amount_o low; data outputs 0. Reset mid-operation abandons the ALU transaction.
- Digit B_NUM_k (IDLE, handled in one cycle, display_we_o=1):
  - If new_entry_q: D := k in significand[7], exponent 0 (k=0 gives zero); digits_q := (k!=0).
  - If also mode_q=FRESH: upper_we_o=1, U := old D, mode_q := PENDING.
  - Otherwise append: significand[7-digits_q] := k, exponent := digits_q, digits_q++. A 9th digit is ignored. Leading zeros are not counted.
  - new_entry_q := 0.
- Operator B_OP_ADD/SUB/MUL/DIV:
  - From REPEAT or FRESH: op_q := op, mode_q := FRESH, new_entry_q := 1, no register writes.
  - From PENDING (chained): ALU computes U op_q D; D := result, U := result; then op_q := new op, mode FRESH, new_entry_q := 1.
- B_OP_EQ launches ALU, then in WAIT:
  - PENDING: left=U, right=D; D := result, U := old D.
  - FRESH: left=D, right=U; D := result, U := old D.
  - REPEAT: left=D, right=U; D := result, U unchanged.
  - All three cases then set mode_q := REPEAT, new_entry_q := 1.
- B_CLEAR: write D=0 and U=0; all internal state to reset values.
- B_NONE and unknown codes: ignored.
- override_shift_amount_o = 1 while digits_q>0 and new_entry_q=0. new_shift_amount_o = digits_q-1.
- Register writes take effect at the clock edge; controller reads registered values thereafter.

Test Plan:
- Reset, 1 + = = = = = -> display 1,1,1,2,3,4,5; upper 0,0,1,1,1,1,1.
- Reset, 3 = 1 + = = -> display 3,3,1,1,1,2; upper 0,0,0,0,1,1.
- Reset, + 3 = 1 + = = = = = -> display 0,3,3,1,1,4,5,6,7,8; upper 0,0,3,3,3,1,1,1,1,1.
- Reset, 1 + 1 = + = + = + = + -> display 1,1,1,2,2,3,3,5,5,8,8.
- Reset, 1 = = = = = = -> display stays 1; upper stays 0.
- ALU in_ready/out_valid delayed several cycles, with new_input pulses during WAIT -> extra inputs ignored; state returns to 0 only after the write. Then digits 1,2,3 -> display 123, shift override 2.
